// File: rtl/mant_divider.sv
// mant_divider: 24-bit mantissa restoring divider, one quotient bit per cycle, 25-bit quotient with sticky.
module mant_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] dividend,
  input  logic [23:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [24:0] quotient,
  output logic        sticky,
  output logic        dbz,
  output logic        ovf
);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state, state_nxt;
  logic [23:0] b;
  logic [24:0] r, q;
  logic [4:0]  cnt;
  logic        exc_dbz, exc_ovf;
  logic [25:0] diff;
  logic        borrow, in_dbz, in_ovf;
  always_comb begin
    diff      = {1'b0, r} - {2'b0, b};
    borrow    = diff[25];
    in_dbz    = divisor == 24'd0;
    in_ovf    = {1'b0, dividend} >= {divisor, 1'b0};
    state_nxt = state == IDLE ? (start ? DIV : IDLE) :
                state == DIV  ? (cnt == 5'd0 ? DONE : DIV) : IDLE;
  end
  // Exceptions run a single throwaway DIV cycle (cnt=0); DONE then reports the saturated result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      b        <= '0;
      r        <= '0;
      q        <= '0;
      cnt      <= '0;
      exc_dbz  <= 1'b0;
      exc_ovf  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
      sticky   <= 1'b0;
      dbz      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            b       <= divisor;
            r       <= {1'b0, dividend};
            q       <= '0;
            cnt     <= in_ovf ? 5'd0 : 5'd24;
            exc_dbz <= in_dbz;
            exc_ovf <= in_ovf;
          end
        end
        DIV: begin
          q[cnt] <= ~borrow;
          r      <= borrow ? {r[23:0], 1'b0} : {diff[23:0], 1'b0};
          cnt    <= cnt == 5'd0 ? cnt : cnt - 5'd1;
        end
        DONE: begin
          quotient <= exc_ovf ? 25'h1FFFFFF : q;
          sticky   <= exc_ovf ? 1'b0 : |r;
          dbz      <= exc_dbz;
          ovf      <= exc_ovf;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
